dec_rr_arbiter: RTL and testbench
=================================

Name: dec_rr_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource among 2**n requesters.
- Selects one requester, holds the grant until the owner finishes, then rotates priority.
- Drives both an encoded grant index and a one-hot grant vector; the one-hot vector is produced by a registered index feeding a parameterised enable-gated decoder.
- Sits between requesting units and the shared resource's select/enable inputs.

Parameters:
- n, 3, index width; requester count N = 2**n.
- MAX_HOLD, 16, cycles before forced release (used only with the optional feature); must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- enab  in  1  arbiter enable; low blocks new grants only.
- req  in  N  per-requester request level.
- done  in  1  owner's end-of-transfer pulse, sampled only in BUSY.
- gnt_vld  out  1  a grant is active.
- gnt_idx  out  n  index of the current owner; holds its last value when gnt_vld=0.
- gnt  out  N  one-hot grant; all zero when gnt_vld=0.
- timeout  out  1  one-cycle pulse on forced release (tied 0 without the optional feature).

Behaviour:
- Clocking: one clock domain. All state is updated on the rising clk edge.
- Reset (rst_n=0 at an edge): state=IDLE, ptr=0, gnt_idx=0, gnt_vld=0, gnt=0, timeout=0, hold counter=0. Reset overrides everything, including an active grant mid-transfer.
- State IDLE:
  - If enab=1 and req≠0, choose the first set bit of req scanning ptr, ptr+1, … N-1, 0, … ptr-1 (circular).
  - Register the choice into gnt_idx and go to BUSY. gnt_vld=1 from the next cycle, so latency is 1 cycle from req sampled to grant.
  - If enab=0 or req=0, remain in IDLE with outputs at 0.
- State BUSY:
  - gnt_vld=1 and gnt=one-hot(gnt_idx).
  - Release when done=1, or when req[gnt_idx]=0 (requester withdraws).
  - On release: gnt_vld and gnt drop at the next edge, ptr ← (gnt_idx+1) mod N (natural n-bit wrap, so 7→0 for n=3), and the state returns to IDLE.
  - Exactly one IDLE cycle separates consecutive grants.
  - Otherwise hold, ignoring req changes of other requesters.
- enab deasserted during BUSY does not revoke the current grant; the transfer completes normally.
- done sampled in IDLE is ignored.
- Simultaneous done and withdrawal is a single release; ptr advances once.
- All requesters active continuously: grants rotate 0,1,…,N-1,0. No requester waits more than N-1 other grants (fairness bound).
- ptr only changes on release or reset.
- gnt is registered. The decoder is combinational from registered gnt_idx, gated by gnt_vld, so gnt is glitch-free relative to clk.

Optional Feature:
- Macro: DEC_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 without a release, a forced release occurs at the next edge: same ptr/state update as a normal release, and timeout pulses high for one cycle, concurrent with gnt_vld falling.
  - A normal release on the same cycle takes precedence; timeout stays 0.
- Undefined:
  - No counter logic is built and timeout is tied 0.
  - A grant may be held indefinitely.

Decomposition:
- Shared package/include holds:
  - State encodings: IDLE=1'b0, BUSY=1'b1.
  - Default n and MAX_HOLD.
- One sub-module is natural: arb_grant_dec.
  - Parameterised n-to-2**n decoder with enable.
  - Inputs gnt_idx and gnt_vld; output gnt.
  - All outputs driven to 0 when disabled, never Z.
- The circular priority scan stays inline in the top level.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with req=8'hFF. Required: gnt=0, gnt_vld=0, gnt_idx=0 throughout. After release with enab=0: still no grant.
- Single requester: enab=1, req=8'h10. Required: one cycle later gnt_idx=4, gnt=8'h10. Pulse done. Required: gnt=0 the next cycle, ptr=5.
- Full rotation: req=8'hFF held, done pulsed each BUSY cycle. Required: gnt_idx sequence 0,1,…,7,0 with one idle cycle between grants (wrap check).
- Priority rotation and withdrawal: ptr=5, req=8'h09. Required: grant idx 0 (idx 3 only after idx 0 is serviced). Drop req[0] mid-grant. Required: release, then grant idx 3.
- Enable and reset mid-operation: deassert enab during BUSY. Required: grant held until done. Assert rst_n=0 during BUSY. Required: gnt=0 and gnt_idx=0 at the next edge.
- Timeout (macro defined, MAX_HOLD=4): req=8'h02, no done. Required: gnt_vld high for exactly 4 cycles, then timeout=1 for 1 cycle and ptr=2. Macro undefined: same stimulus holds the grant for 100 cycles with timeout=0.

Source files
------------

// File: rtl/dec_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dec_rr_arbiter_pkg
// Shared definitions for the round-robin arbiter slice:
//   - arb_state_e  : arbiter FSM state encoding (IDLE / BUSY)
//   - ARB_N_DEF    : default index width n (requester count 2**n)
//   - ARB_MAX_HOLD_DEF : default forced-release limit in cycles
// ---------------------------------------------------------------------------
package dec_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_N_DEF        = 3;
    localparam int ARB_MAX_HOLD_DEF = 16;

endpackage

// File: rtl/dec_rr_arbiter_arb_grant_dec.sv
// ---------------------------------------------------------------------------
// arb_grant_dec
// n-to-2**n one-hot decoder with enable. Output is all zeros while the
// enable is low (never Z).
// Ports:
//   gnt_idx [n-1:0]    in   index to decode
//   gnt_vld            in   decoder enable
//   gnt     [2**n-1:0] out  one-hot of gnt_idx, or 0 when disabled
// ---------------------------------------------------------------------------
import dec_rr_arbiter_pkg::*;

module arb_grant_dec #(
    parameter int n = ARB_N_DEF
) (
    input  logic [n-1:0]      gnt_idx,
    input  logic              gnt_vld,
    output logic [2**n-1:0]   gnt
);

    always_comb begin
        gnt = '0;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dec_rr_arbiter
// Round-robin arbiter sharing one resource among 2**n requesters. A grant is
// held until the owner pulses done or drops its request; priority then
// rotates to the requester after the released owner.
// Optional build macro: DEC_RR_ARBITER_TIMEOUT_EN
//   defined   -> a grant held MAX_HOLD cycles is forcibly released and
//                timeout pulses for one cycle
//   undefined -> no hold counter, timeout tied 0
// Ports:
//   clk                in   rising-edge clock
//   rst_n              in   synchronous active-low reset
//   enab               in   enable for new grants (does not revoke a grant)
//   req     [2**n-1:0] in   request levels
//   done               in   owner end-of-transfer pulse (used only in BUSY)
//   gnt_vld            out  a grant is active
//   gnt_idx [n-1:0]    out  current/last owner index
//   gnt     [2**n-1:0] out  one-hot grant, zero when gnt_vld=0
//   timeout            out  one-cycle pulse on forced release
//
// state | meaning
// IDLE  | no grant; scan req from ptr and grant on the next edge
// BUSY  | grant held by gnt_idx until done / withdrawal (/ hold limit)
// ---------------------------------------------------------------------------
import dec_rr_arbiter_pkg::*;

module dec_rr_arbiter #(
    parameter int n        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enab,
    input  logic [2**n-1:0]   req,
    input  logic              done,
    output logic              gnt_vld,
    output logic [n-1:0]      gnt_idx,
    output logic [2**n-1:0]   gnt,
    output logic              timeout
);

    localparam int N = 2**n;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("dec_rr_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_e       state_q, state_d;
    logic [n-1:0]     ptr_q, ptr_d;
    logic [n-1:0]     gnt_idx_q, gnt_idx_d;
    logic             timeout_q, timeout_d;

    logic             scan_hit;
    logic [n-1:0]     scan_idx;
    logic [n-1:0]     cand;
    logic             rel_normal;
    logic             rel_force;

`ifdef DEC_RR_ARBITER_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0]    hold_q, hold_d;
`endif

    // Circular scan ptr, ptr+1, ..., wrapping naturally on n bits.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = ptr_q;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + i[n-1:0];
            if (!scan_hit && req[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    assign rel_normal = done || !req[gnt_idx_q];

`ifdef DEC_RR_ARBITER_TIMEOUT_EN
    // A normal release in the same cycle wins, so timeout stays low then.
    assign rel_force = !rel_normal && (hold_q == HOLD_LAST);
`else
    assign rel_force = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (enab && scan_hit) begin
                    state_d   = BUSY;
                    gnt_idx_d = scan_idx;
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
                    hold_d    = '0;
`endif
                end
            end
            BUSY: begin
                if (rel_normal || rel_force) begin
                    state_d   = IDLE;
                    ptr_d     = gnt_idx_q + 1'b1;
                    timeout_d = rel_force;
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
                    hold_d    = '0;
`endif
                end else begin
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
                    hold_d    = hold_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            timeout_q <= 1'b0;
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            timeout_q <= timeout_d;
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign gnt_vld = (state_q == BUSY);
    assign gnt_idx = gnt_idx_q;
    assign timeout = timeout_q;

    arb_grant_dec #(.n(n)) u_grant_dec (
        .gnt_idx (gnt_idx_q),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

endmodule

// File: tb/tb_dec_rr_arbiter.sv
module tb_dec_rr_arbiter;

    localparam int NB  = 3;
    localparam int N   = 2**NB;
    localparam int MH  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enab;
    logic [N-1:0]  req;
    logic          done;
    logic          gnt_vld;
    logic [NB-1:0] gnt_idx;
    logic [N-1:0]  gnt;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dec_rr_arbiter #(.n(NB), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enab    (enab),
        .req     (req),
        .done    (done),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt     (gnt),
        .timeout (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: whose turn it is, which requester follows it in line,
    // and how many cycles the current owner has held the resource.
    bit m_busy;
    int m_owner;
    int m_next;
    int m_held;
    bit m_to;
    bit m_rel;
    bit m_force;
    int m_best;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_next  = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_busy) begin
                m_held++;
                m_rel   = done || !req[m_owner];
                m_force = 1'b0;
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
                m_force = !m_rel && (m_held >= MH);
`endif
                if (m_rel || m_force) begin
                    m_busy = 1'b0;
                    m_next = (m_owner + 1) % N;
                    m_to   = m_force;
                end
            end else if (enab && req != '0) begin
                // Requester at the smallest circular distance from m_next.
                m_best = -1;
                for (int d = N - 1; d >= 0; d--) begin
                    if (req[(m_next + d) % N]) m_best = (m_next + d) % N;
                end
                m_owner = m_best;
                m_busy  = 1'b1;
                m_held  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt_vld", int'(gnt_vld), int'(m_busy));
            check("gnt_idx", int'(gnt_idx), m_owner);
            check("gnt", int'(gnt), m_busy ? (1 << m_owner) : 0);
            check("timeout", int'(timeout), int'(m_to));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0;
        enab  = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;

        // Reset with all requests high.
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        check("rst_vld", int'(gnt_vld), 0);
        check("rst_idx", int'(gnt_idx), 0);
        check("rst_gnt", int'(gnt), 0);
        rst_n = 1'b1;
        cyc(3);
        check("dis_vld", int'(gnt_vld), 0);

        // Single requester 4, then done -> ptr 5.
        enab = 1'b1;
        req  = 8'h10;
        cyc(1);
        check("single_idx", int'(gnt_idx), 4);
        check("single_gnt", int'(gnt), 8'h10);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        check("single_rel", int'(gnt), 0);
        req = 8'h21;
        cyc(1);
        check("ptr5_idx", int'(gnt_idx), 5);
        req = 8'h00;
        cyc(1);

        // Full rotation from ptr 0 with done held high.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        req   = 8'hFF;
        done  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc(1);
            check("rot_vld", int'(gnt_vld), 1);
            check("rot_idx", int'(gnt_idx), k % N);
            cyc(1);
            check("rot_gap", int'(gnt_vld), 0);
        end
        done = 1'b0;
        req  = 8'h00;
        cyc(1);

        // Bring ptr to 5, then req=0x09 -> 0 first, withdraw -> 3.
        req = 8'h10;
        cyc(1);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        req  = 8'h09;
        cyc(1);
        check("prio_idx0", int'(gnt_idx), 0);
        cyc(1);
        check("prio_hold", int'(gnt_idx), 0);
        req = 8'h08;
        cyc(1);
        check("wd_rel", int'(gnt_vld), 0);
        cyc(1);
        check("wd_idx3", int'(gnt_idx), 3);
        check("wd_vld", int'(gnt_vld), 1);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        req  = 8'h00;
        cyc(1);

        // Enable drop during BUSY keeps the grant; reset mid-grant clears it.
        req = 8'h04;
        cyc(1);
        enab = 1'b0;
        cyc(2);
        check("en_hold_vld", int'(gnt_vld), 1);
        check("en_hold_idx", int'(gnt_idx), 2);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(1);
        check("en_off_vld", int'(gnt_vld), 0);
        enab = 1'b1;
        req  = 8'h40;
        cyc(1);
        check("pre_rst_idx", int'(gnt_idx), 6);
        rst_n = 1'b0;
        cyc(1);
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_idx", int'(gnt_idx), 0);
        rst_n = 1'b1;
        req   = 8'h00;
        cyc(1);

        // Hold limit.
        req = 8'h02;
        cnt = 0;
        cyc(1);
`ifdef DEC_RR_ARBITER_TIMEOUT_EN
        while (gnt_vld && cnt < 50) begin
            cnt++;
            cyc(1);
        end
        check("to_len", cnt, MH);
        check("to_pulse", int'(timeout), 1);
`else
        repeat (100) begin
            if (gnt_vld) cnt++;
            cyc(1);
        end
        check("hold_len", cnt, 100);
        check("hold_to", int'(timeout), 0);
`endif
        req  = 8'h00;
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(1);
        req = 8'h06;
        cyc(1);
        check("after_hold_idx", int'(gnt_idx), 2);
        req = 8'h00;
        cyc(1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            enab  = ($urandom_range(0, 9) != 0);
            done  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            cyc(1);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
